// File: rtl/gate_deadtime_driver.sv
// gate_deadtime_driver
// Turns the single ICO switching command into complementary half-bridge gate
// drives (Gate_HI / Gate_LO) with programmable dead time, plus a latched,
// filtered overcurrent shutdown that holds off restart for HOLD_CYCLES.
// Optional build macro: MIN_PULSE_EN (minimum on-time per conducting state).
module gate_deadtime_driver #(
  parameter int DT_CYCLES   = 40,
  parameter int DT_W        = 8,
  parameter int OC_FILT     = 4,
  parameter int HOLD_CYCLES = 40000,
  parameter int HOLD_W      = 16,
  parameter int MIN_ON      = 20
) (
  input  logic       clk40MHz,
  input  logic       rst_n,
  input  logic       gate_in,
  input  logic       enable,
  input  logic       oc_n,
  input  logic       fault_clr,
  output logic       Gate_HI,
  output logic       Gate_LO,
  output logic       fault,
  output logic [2:0] state_dbg
);

  localparam int OCW = $clog2(OC_FILT + 1);

  // Constants must fit their counters, otherwise dead time or hold-off shrinks silently.
  if (DT_CYCLES < 1 || DT_CYCLES >= (1 << DT_W) || HOLD_CYCLES >= (1 << HOLD_W) ||
      OC_FILT < 1 || MIN_ON < 0) begin : g_bad_cfg
    $error("gate_deadtime_driver: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DT_HI = 3'd1,
    HI    = 3'd2,
    DT_LO = 3'd3,
    LO    = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              gate_meta;
  logic              gate_s;
  logic              oc_meta;
  logic              oc_s;
  logic [OCW-1:0]    oc_cnt;
  logic              flt_det;
  logic [DT_W-1:0]   dt_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              dt_load;
  logic              hold_load;
  logic              on_ok;
  logic              gate_hi_d;
  logic              gate_lo_d;
  logic              fault_d;

  // Two-flop synchronizers; oc path presets to the no-fault level
  always_ff @(posedge clk40MHz) begin
    if (!rst_n) begin
      gate_meta <= 1'b0;
      gate_s    <= 1'b0;
      oc_meta   <= 1'b1;
      oc_s      <= 1'b1;
    end else begin
      gate_meta <= gate_in;
      gate_s    <= gate_meta;
      oc_meta   <= oc_n;
      oc_s      <= oc_meta;
    end
  end

  // Overcurrent glitch filter: counts consecutive low samples, saturating
  always_ff @(posedge clk40MHz) begin
    if (!rst_n)
      oc_cnt <= '0;
    else if (oc_s)
      oc_cnt <= '0;
    else if (oc_cnt != OCW'(OC_FILT))
      oc_cnt <= oc_cnt + 1'b1;
  end

  assign flt_det = (oc_cnt == OCW'(OC_FILT));

  // Dead-time counter, loaded on every entry into DT_HI/DT_LO
  always_ff @(posedge clk40MHz) begin
    if (!rst_n)
      dt_cnt <= '0;
    else if (dt_load)
      dt_cnt <= DT_W'(DT_CYCLES);
    else if ((state == DT_HI || state == DT_LO) && dt_cnt != '0)
      dt_cnt <= dt_cnt - 1'b1;
  end

  // Fault hold-off counter, reloaded by every detection, then runs down to 0
  always_ff @(posedge clk40MHz) begin
    if (!rst_n)
      hold_cnt <= '0;
    else if (hold_load)
      hold_cnt <= HOLD_W'(HOLD_CYCLES);
    else if (state == FAULT && hold_cnt != '0)
      hold_cnt <= hold_cnt - 1'b1;
  end

`ifdef MIN_PULSE_EN
  localparam int ONW = (MIN_ON > 0) ? $clog2(MIN_ON + 1) : 1;
  logic [ONW-1:0] on_cnt;

  // Minimum on-time counter, armed on each entry into HI or LO
  always_ff @(posedge clk40MHz) begin
    if (!rst_n)
      on_cnt <= '0;
    else if ((state_nxt == HI || state_nxt == LO) && state_nxt != state)
      on_cnt <= ONW'(MIN_ON);
    else if ((state == HI || state == LO) && on_cnt != '0)
      on_cnt <= on_cnt - 1'b1;
  end

  // Release on the edge where the counter reaches 0, giving exactly MIN_ON cycles on.
  assign on_ok = (on_cnt <= ONW'(1));
`else
  assign on_ok = 1'b1;
`endif

  // Next-state logic: fault beats disable beats the switching command
  always_comb begin
    state_nxt = state;
    dt_load   = 1'b0;
    hold_load = 1'b0;
    if (flt_det) begin
      state_nxt = FAULT;
      hold_load = 1'b1;
    end else if (state == FAULT) begin
      if (hold_cnt == '0 && oc_s && fault_clr)
        state_nxt = IDLE;
    end else if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          dt_load   = 1'b1;
          state_nxt = gate_s ? DT_HI : DT_LO;
        end
        DT_HI, DT_LO: begin
          if (dt_cnt <= DT_W'(1))
            state_nxt = gate_s ? HI : LO;
        end
        HI: begin
          if (!gate_s && on_ok) begin
            dt_load   = 1'b1;
            state_nxt = DT_LO;
          end
        end
        LO: begin
          if (gate_s && on_ok) begin
            dt_load   = 1'b1;
            state_nxt = DT_HI;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode from the next state so the drives are registered with it
  always_comb begin
    gate_hi_d = (state_nxt == HI);
    gate_lo_d = (state_nxt == LO);
    fault_d   = (state_nxt == FAULT);
  end

  // State register and registered gate/fault outputs
  always_ff @(posedge clk40MHz) begin
    if (!rst_n) begin
      state   <= IDLE;
      Gate_HI <= 1'b0;
      Gate_LO <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state   <= state_nxt;
      Gate_HI <= gate_hi_d;
      Gate_LO <= gate_lo_d;
      fault   <= fault_d;
    end
  end

  assign state_dbg = state;

endmodule
